// File: rtl/commit_trace_buffer_pkg.sv
// ============================================================================
//  Module   : trace_pkg
//  Purpose  : Shared FSM encodings, record layout and sizing helpers for the
//             commit trace buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    localparam int TR_DATA_W = 32;
    localparam int TR_SEQ_W  = 16;

    // Record layout, MSB to LSB: {seq, pc, inst}
    localparam int REC_W    = TR_SEQ_W + 2 * TR_DATA_W;
    localparam int INST_LSB = 0;
    localparam int PC_LSB   = TR_DATA_W;
    localparam int SEQ_LSB  = 2 * TR_DATA_W;

    function automatic int rec_w(input int seq_w, input int data_w);
        return seq_w + 2 * data_w;
    endfunction

    function automatic int pc_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int seq_lsb(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/commit_trace_buffer_if.sv
// ============================================================================
//  Module   : commit_trace_buffer_if
//  Purpose  : Commit-record input and valid/ready drain port of the trace buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface commit_trace_buffer_if #(
    parameter int DATA_W = 32,
    parameter int SEQ_W  = 16
);
    logic              commit_valid;
    logic [DATA_W-1:0] commit_pc;
    logic [DATA_W-1:0] commit_inst;
    logic              out_valid;
    logic              out_ready;
    logic [SEQ_W-1:0]  out_seq;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_inst;

    // Environment side: CPU commit stream plus the trace reader
    modport master (
        output commit_valid, commit_pc, commit_inst, out_ready,
        input  out_valid, out_seq, out_pc, out_inst
    );

    modport slave (
        input  commit_valid, commit_pc, commit_inst, out_ready,
        output out_valid, out_seq, out_pc, out_inst
    );
endinterface

`default_nettype wire

// File: rtl/commit_trace_buffer_fifo.sv
// ============================================================================
//  Module   : trace_fifo
//  Purpose  : First-word-fall-through FIFO with optional overwrite-oldest push.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   clear_i,
    input  wire logic                   push_i,
    input  wire logic                   force_push_i,
    input  wire logic                   pop_i,
    input  wire logic [WIDTH-1:0]       wdata_i,
    output logic      [WIDTH-1:0]       rdata_o,
    output logic      [$clog2(DEPTH):0] level_o,
    output logic                        full_o,
    output logic                        empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_ovw;
    logic w_push;
    logic w_rd_adv;

    assign w_full  = (level_q == (AW+1)'(DEPTH));
    assign w_empty = (level_q == '0);

    // Overwrite only when full with no concurrent pop: the oldest entry is
    // discarded by advancing the read pointer alongside the write.
    assign w_pop    = pop_i & ~w_empty & ~clear_i;
    assign w_ovw    = push_i & force_push_i & w_full & ~w_pop & ~clear_i;
    assign w_push   = push_i & ~clear_i & (~w_full | w_pop | w_ovw);
    assign w_rd_adv = w_pop | w_ovw;

    always_comb begin
        level_d = level_q;
        case ({w_push, w_rd_adv})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push)   wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_rd_adv) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = w_empty ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = w_full;
    assign empty_o = w_empty;

endmodule

`default_nettype wire

// File: rtl/commit_trace_buffer.sv
// ============================================================================
//  Module   : commit_trace_buffer
//  Purpose  : Captures retired-instruction records into an on-chip FIFO.
//             Optional commit-PC window filter: define TRACE_PC_FILTER_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W     = TR_DATA_W,
    parameter int DEPTH      = 16,
    parameter int SEQ_W      = TR_SEQ_W,
    parameter int STOP_COUNT = 0,
    parameter int RING_MODE  = 0
) (
    input  wire logic                   clk_in,
    input  wire logic                   reset,
    input  wire logic                   cap_en,
    input  wire logic                   clear,
`ifdef TRACE_PC_FILTER_EN
    input  wire logic [DATA_W-1:0]      filt_lo,
    input  wire logic [DATA_W-1:0]      filt_hi,
`endif
    commit_trace_buffer_if.slave        bus,
    output logic      [$clog2(DEPTH):0] level,
    output logic                        overflow,
    output logic                        halted
);
    localparam int RW    = rec_w(SEQ_W, DATA_W);
    localparam int PC_LO = pc_lsb(DATA_W);
    localparam int SQ_LO = seq_lsb(DATA_W);
    localparam int CNT_W = (STOP_COUNT > 0) ? $clog2(STOP_COUNT + 1) : 1;

    state_t           state_q;
    logic             halted_q;
    logic [SEQ_W-1:0] seq_q;
    logic [SEQ_W-1:0] seq_d;
    logic [CNT_W-1:0] captured_q;
    logic [CNT_W-1:0] captured_d;
    logic             overflow_q;
    logic             overflow_d;

    logic          w_eligible;
    logic          w_attempt;
    logic          w_pop;
    logic          w_stop_hit;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [RW-1:0] w_wdata;
    logic [RW-1:0] w_rdata;

`ifdef TRACE_PC_FILTER_EN
    assign w_eligible = (bus.commit_pc >= filt_lo) && (bus.commit_pc <= filt_hi);
`else
    assign w_eligible = 1'b1;
`endif

    // clear outranks any push or pop arriving in the same cycle
    assign w_attempt  = (state_q == ST_CAPTURE) & bus.commit_valid & w_eligible & ~clear;
    assign w_pop      = bus.out_ready & ~w_fifo_empty & ~clear;
    assign w_stop_hit = (STOP_COUNT != 0) & w_attempt &
                        ((captured_q + CNT_W'(1)) == CNT_W'(STOP_COUNT));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cap_en) state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (w_stop_hit) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else if (!cap_en) begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    if (clear) begin
                        state_q  <= ST_IDLE;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Sequence advances on dropped attempts too, so readers can spot gaps
    always_comb begin
        seq_d      = seq_q;
        captured_d = captured_q;
        overflow_d = overflow_q;
        if (clear) begin
            seq_d      = '0;
            captured_d = '0;
            overflow_d = 1'b0;
        end else if (w_attempt) begin
            seq_d = seq_q + SEQ_W'(1);
            if (STOP_COUNT != 0) captured_d = captured_q + CNT_W'(1);
            if (w_fifo_full && !w_pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            seq_q      <= '0;
            captured_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            captured_q <= captured_d;
            overflow_q <= overflow_d;
        end
    end

    assign w_wdata = {seq_q, bus.commit_pc, bus.commit_inst};

    trace_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk_in),
        .rst          (reset),
        .clear_i      (clear),
        .push_i       (w_attempt),
        .force_push_i (RING_MODE != 0),
        .pop_i        (w_pop),
        .wdata_i      (w_wdata),
        .rdata_o      (w_rdata),
        .level_o      (level),
        .full_o       (w_fifo_full),
        .empty_o      (w_fifo_empty)
    );

    assign bus.out_valid = ~w_fifo_empty;
    assign bus.out_seq   = w_rdata[SQ_LO +: SEQ_W];
    assign bus.out_pc    = w_rdata[PC_LO +: DATA_W];
    assign bus.out_inst  = w_rdata[0 +: DATA_W];
    assign overflow      = overflow_q;
    assign halted        = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
// ============================================================================
//  Module   : tb_commit_trace_buffer
//  Purpose  : Self-checking bench for drop, ring and auto-halt configurations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_trace_buffer;

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] inst;
    } rec_t;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        cap_en;
    logic        clear;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
`ifdef TRACE_PC_FILTER_EN
    logic [31:0] filt_lo;
    logic [31:0] filt_hi;
`endif

    logic [2:0] lvl_drop;
    logic [2:0] lvl_ring;
    logic [3:0] lvl_stop;
    logic ovf_drop, ovf_ring, ovf_stop;
    logic hlt_drop, hlt_ring, hlt_stop;

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t q_drop[$];
    rec_t q_ring[$];
    rec_t q_stop[$];
    rec_t exp_r;

    always #5 clk = ~clk;

    commit_trace_buffer_if #(.DATA_W(32), .SEQ_W(16)) if_drop ();
    commit_trace_buffer_if #(.DATA_W(32), .SEQ_W(16)) if_ring ();
    commit_trace_buffer_if #(.DATA_W(32), .SEQ_W(16)) if_stop ();

    assign if_drop.commit_valid = commit_valid;
    assign if_drop.commit_pc    = commit_pc;
    assign if_drop.commit_inst  = commit_inst;
    assign if_ring.commit_valid = commit_valid;
    assign if_ring.commit_pc    = commit_pc;
    assign if_ring.commit_inst  = commit_inst;
    assign if_stop.commit_valid = commit_valid;
    assign if_stop.commit_pc    = commit_pc;
    assign if_stop.commit_inst  = commit_inst;

    commit_trace_buffer #(.DATA_W(32), .DEPTH(4), .SEQ_W(16), .STOP_COUNT(0), .RING_MODE(0)) u_drop (
        .clk_in (clk), .reset (reset), .cap_en (cap_en), .clear (clear),
`ifdef TRACE_PC_FILTER_EN
        .filt_lo (filt_lo), .filt_hi (filt_hi),
`endif
        .bus (if_drop), .level (lvl_drop), .overflow (ovf_drop), .halted (hlt_drop)
    );

    commit_trace_buffer #(.DATA_W(32), .DEPTH(4), .SEQ_W(16), .STOP_COUNT(0), .RING_MODE(1)) u_ring (
        .clk_in (clk), .reset (reset), .cap_en (cap_en), .clear (clear),
`ifdef TRACE_PC_FILTER_EN
        .filt_lo (filt_lo), .filt_hi (filt_hi),
`endif
        .bus (if_ring), .level (lvl_ring), .overflow (ovf_ring), .halted (hlt_ring)
    );

    commit_trace_buffer #(.DATA_W(32), .DEPTH(8), .SEQ_W(16), .STOP_COUNT(5), .RING_MODE(0)) u_stop (
        .clk_in (clk), .reset (reset), .cap_en (cap_en), .clear (clear),
`ifdef TRACE_PC_FILTER_EN
        .filt_lo (filt_lo), .filt_hi (filt_hi),
`endif
        .bus (if_stop), .level (lvl_stop), .overflow (ovf_stop), .halted (hlt_stop)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_inst  = inst_of(pc);
        tick();
        commit_valid = 1'b0;
    endtask

    // Flush and give IDLE one edge to re-enter CAPTURE
    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        q_drop.delete();
        q_ring.delete();
        q_stop.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({if_drop.out_valid, lvl_drop, ovf_drop, hlt_drop, if_drop.out_seq, if_drop.out_pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b level=%0d ovf=%b halted=%b seq=%0d pc=%h expected all 0",
                     if_drop.out_valid, lvl_drop, ovf_drop, hlt_drop, if_drop.out_seq, if_drop.out_pc);
        end
        n_checks++;
        if ({hlt_stop, lvl_stop, lvl_ring} !== '0) begin
            n_fail++;
            $display("FAIL reset_others: got halted=%b lvl_stop=%0d lvl_ring=%0d expected 0", hlt_stop, lvl_stop, lvl_ring);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cap_enable();
        do_clear();
        cap_en = 1'b0;
        tick();
        commit(BASE);
        n_checks++;
        if (lvl_drop !== 3'd0) begin
            n_fail++;
            $display("FAIL cap_en_low_no_push: got level=%0d expected 0", lvl_drop);
        end
        cap_en = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_clear();
        for (int i = 0; i < 3; i++) begin
            q_drop.push_back('{seq: 16'(i), pc: BASE + 32'(4*i), inst: inst_of(BASE + 32'(4*i))});
            commit(BASE + 32'(4*i));
        end
        n_checks++;
        if (lvl_drop !== 3'd3 || ovf_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_level: got level=%0d ovf=%b expected level=3 ovf=0", lvl_drop, ovf_drop);
        end
        if_drop.out_ready = 1'b1;
        for (int c = 0; c < 20 && q_drop.size() > 0; c++) begin
            if (if_drop.out_valid) begin
                exp_r = q_drop.pop_front();
                n_checks++;
                if ({if_drop.out_seq, if_drop.out_pc, if_drop.out_inst} !== exp_r) begin
                    n_fail++;
                    $display("FAIL basic_drain: got seq=%0d pc=%h inst=%h expected seq=%0d pc=%h inst=%h",
                             if_drop.out_seq, if_drop.out_pc, if_drop.out_inst, exp_r.seq, exp_r.pc, exp_r.inst);
                end
            end
            tick();
        end
        if_drop.out_ready = 1'b0;
        n_checks++;
        if (q_drop.size() != 0 || if_drop.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain_end: got left=%0d valid=%b expected 0 and 0", q_drop.size(), if_drop.out_valid);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 6; i++) begin
            if (i < 4)  q_drop.push_back('{seq: 16'(i), pc: BASE + 32'(4*i), inst: inst_of(BASE + 32'(4*i))});
            if (i >= 2) q_ring.push_back('{seq: 16'(i), pc: BASE + 32'(4*i), inst: inst_of(BASE + 32'(4*i))});
            commit(BASE + 32'(4*i));
        end
        n_checks++;
        if (lvl_drop !== 3'd4 || ovf_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_full: got level=%0d ovf=%b expected level=4 ovf=1", lvl_drop, ovf_drop);
        end
        n_checks++;
        if (lvl_ring !== 3'd4 || ovf_ring !== 1'b1) begin
            n_fail++;
            $display("FAIL ring_full: got level=%0d ovf=%b expected level=4 ovf=1", lvl_ring, ovf_ring);
        end
        if_drop.out_ready = 1'b1;
        for (int c = 0; c < 20 && q_drop.size() > 0; c++) begin
            if (if_drop.out_valid) begin
                exp_r = q_drop.pop_front();
                n_checks++;
                if ({if_drop.out_seq, if_drop.out_pc, if_drop.out_inst} !== exp_r) begin
                    n_fail++;
                    $display("FAIL drop_drain: got seq=%0d pc=%h expected seq=%0d pc=%h",
                             if_drop.out_seq, if_drop.out_pc, exp_r.seq, exp_r.pc);
                end
            end
            tick();
        end
        if_drop.out_ready = 1'b0;
        if_ring.out_ready = 1'b1;
        for (int c = 0; c < 20 && q_ring.size() > 0; c++) begin
            if (if_ring.out_valid) begin
                exp_r = q_ring.pop_front();
                n_checks++;
                if ({if_ring.out_seq, if_ring.out_pc, if_ring.out_inst} !== exp_r) begin
                    n_fail++;
                    $display("FAIL ring_drain: got seq=%0d pc=%h expected seq=%0d pc=%h",
                             if_ring.out_seq, if_ring.out_pc, exp_r.seq, exp_r.pc);
                end
            end
            tick();
        end
        if_ring.out_ready = 1'b0;
        n_checks++;
        if (q_drop.size() != 0 || q_ring.size() != 0 || if_drop.out_valid !== 1'b0 || if_ring.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_drain_end: got left=%0d/%0d valid=%b/%b expected 0",
                     q_drop.size(), q_ring.size(), if_drop.out_valid, if_ring.out_valid);
        end
        // Dropped attempts still consumed sequence numbers 4 and 5
        commit(BASE + 32'h100);
        n_checks++;
        if (if_drop.out_seq !== 16'd6 || ovf_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_gap: got seq=%0d ovf=%b expected seq=6 ovf=1", if_drop.out_seq, ovf_drop);
        end
    endtask

    task automatic test_stop_count();
        do_clear();
        for (int i = 0; i < 8; i++) begin
            if (i < 5) q_stop.push_back('{seq: 16'(i), pc: BASE + 32'(4*i), inst: inst_of(BASE + 32'(4*i))});
            commit(BASE + 32'(4*i));
            n_checks++;
            if (hlt_stop !== (i >= 4)) begin
                n_fail++;
                $display("FAIL stop_halted_%0d: got halted=%b expected %b", i, hlt_stop, (i >= 4));
            end
        end
        n_checks++;
        if (lvl_stop !== 4'd5 || ovf_stop !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_level: got level=%0d ovf=%b expected level=5 ovf=0", lvl_stop, ovf_stop);
        end
        if_stop.out_ready = 1'b1;
        for (int c = 0; c < 20 && q_stop.size() > 2; c++) begin
            if (if_stop.out_valid) begin
                exp_r = q_stop.pop_front();
                n_checks++;
                if ({if_stop.out_seq, if_stop.out_pc, if_stop.out_inst} !== exp_r) begin
                    n_fail++;
                    $display("FAIL stop_drain: got seq=%0d pc=%h expected seq=%0d pc=%h",
                             if_stop.out_seq, if_stop.out_pc, exp_r.seq, exp_r.pc);
                end
            end
            tick();
        end
        if_stop.out_ready = 1'b0;
        commit(BASE + 32'h200);
        n_checks++;
        if (lvl_stop !== 4'd2 || hlt_stop !== 1'b1 || if_stop.out_seq !== 16'd3) begin
            n_fail++;
            $display("FAIL stop_halted_ignores: got level=%0d halted=%b seq=%0d expected level=2 halted=1 seq=3",
                     lvl_stop, hlt_stop, if_stop.out_seq);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++;
        if (hlt_stop !== 1'b0 || lvl_stop !== 4'd0 || if_stop.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_clear: got halted=%b level=%0d valid=%b expected 0 0 0",
                     hlt_stop, lvl_stop, if_stop.out_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_clear();
        for (int i = 0; i < 4; i++) begin
            q_drop.push_back('{seq: 16'(i), pc: BASE + 32'(4*i), inst: inst_of(BASE + 32'(4*i))});
            commit(BASE + 32'(4*i));
        end
        if_drop.out_ready = 1'b1;
        exp_r = q_drop.pop_front();
        n_checks++;
        if ({if_drop.out_seq, if_drop.out_pc, if_drop.out_inst} !== exp_r) begin
            n_fail++;
            $display("FAIL full_pushpop_head: got seq=%0d expected seq=%0d", if_drop.out_seq, exp_r.seq);
        end
        q_drop.push_back('{seq: 16'd4, pc: BASE + 32'h10, inst: inst_of(BASE + 32'h10)});
        commit(BASE + 32'h10);
        if_drop.out_ready = 1'b0;
        n_checks++;
        if (lvl_drop !== 3'd4 || ovf_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pushpop: got level=%0d ovf=%b expected level=4 ovf=0", lvl_drop, ovf_drop);
        end
        if_drop.out_ready = 1'b1;
        for (int c = 0; c < 20 && q_drop.size() > 0; c++) begin
            if (if_drop.out_valid) begin
                exp_r = q_drop.pop_front();
                n_checks++;
                if ({if_drop.out_seq, if_drop.out_pc, if_drop.out_inst} !== exp_r) begin
                    n_fail++;
                    $display("FAIL b2b_drain: got seq=%0d pc=%h expected seq=%0d pc=%h",
                             if_drop.out_seq, if_drop.out_pc, exp_r.seq, exp_r.pc);
                end
            end
            tick();
        end
        // Empty FIFO with push and pop together: push only, no bypass
        commit(BASE + 32'h14);
        if_drop.out_ready = 1'b0;
        n_checks++;
        if (lvl_drop !== 3'd1 || if_drop.out_valid !== 1'b1 || if_drop.out_seq !== 16'd5) begin
            n_fail++;
            $display("FAIL empty_pushpop: got level=%0d valid=%b seq=%0d expected level=1 valid=1 seq=5",
                     lvl_drop, if_drop.out_valid, if_drop.out_seq);
        end
    endtask

    task automatic test_reset_mid_capture();
        do_clear();
        for (int i = 0; i < 3; i++) commit(BASE + 32'(4*i));
        n_checks++;
        if (lvl_drop !== 3'd3) begin
            n_fail++;
            $display("FAIL midrst_pre: got level=%0d expected 3", lvl_drop);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (lvl_drop !== 3'd0 || if_drop.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got level=%0d valid=%b expected 0 0", lvl_drop, if_drop.out_valid);
        end
        tick();
        reset = 1'b0;
        commit_valid = 1'b1;
        commit_pc    = BASE + 32'h40;
        commit_inst  = inst_of(BASE + 32'h40);
        tick();
        n_checks++;
        if (lvl_drop !== 3'd0 || if_drop.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: got level=%0d valid=%b expected 0 0", lvl_drop, if_drop.out_valid);
        end
        tick();
        commit_valid = 1'b0;
        n_checks++;
        if (lvl_drop !== 3'd1 || if_drop.out_seq !== 16'd0 || if_drop.out_pc !== BASE + 32'h40) begin
            n_fail++;
            $display("FAIL midrst_resume: got level=%0d seq=%0d pc=%h expected level=1 seq=0 pc=%h",
                     lvl_drop, if_drop.out_seq, if_drop.out_pc, BASE + 32'h40);
        end
    endtask

`ifdef TRACE_PC_FILTER_EN
    task automatic test_filter();
        int k;
        k = 0;
        filt_lo = BASE + 32'h10;
        filt_hi = BASE + 32'h20;
        do_clear();
        for (int i = 0; i < 12; i++) begin
            if (BASE + 32'(4*i) >= filt_lo && BASE + 32'(4*i) <= filt_hi) begin
                q_stop.push_back('{seq: 16'(k), pc: BASE + 32'(4*i), inst: inst_of(BASE + 32'(4*i))});
                k++;
            end
            commit(BASE + 32'(4*i));
        end
        n_checks++;
        if (lvl_stop !== 4'd5) begin
            n_fail++;
            $display("FAIL filter_level: got level=%0d expected 5", lvl_stop);
        end
        if_stop.out_ready = 1'b1;
        for (int c = 0; c < 20 && q_stop.size() > 0; c++) begin
            if (if_stop.out_valid) begin
                exp_r = q_stop.pop_front();
                n_checks++;
                if ({if_stop.out_seq, if_stop.out_pc, if_stop.out_inst} !== exp_r) begin
                    n_fail++;
                    $display("FAIL filter_drain: got seq=%0d pc=%h expected seq=%0d pc=%h",
                             if_stop.out_seq, if_stop.out_pc, exp_r.seq, exp_r.pc);
                end
            end
            tick();
        end
        if_stop.out_ready = 1'b0;
        n_checks++;
        if (q_stop.size() != 0 || if_stop.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL filter_drain_end: got left=%0d valid=%b expected 0 0", q_stop.size(), if_stop.out_valid);
        end
        filt_lo = 32'h0;
        filt_hi = 32'hFFFF_FFFF;
    endtask
`endif

    initial begin
        reset             = 1'b1;
        cap_en            = 1'b0;
        clear             = 1'b0;
        commit_valid      = 1'b0;
        commit_pc         = '0;
        commit_inst       = '0;
        if_drop.out_ready = 1'b0;
        if_ring.out_ready = 1'b0;
        if_stop.out_ready = 1'b0;
`ifdef TRACE_PC_FILTER_EN
        filt_lo = 32'h0;
        filt_hi = 32'hFFFF_FFFF;
`endif
        test_reset();
        cap_en = 1'b1;
        tick();
        test_cap_enable();
        test_basic();
        test_overflow();
        test_stop_count();
        test_back_to_back();
        test_reset_mid_capture();
`ifdef TRACE_PC_FILTER_EN
        test_filter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit reached");
    end

endmodule

`default_nettype wire
